// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer with branch-target LUT, start/done handshake and run-cycle counter
module fetch_sequencer #(
  parameter int PC_W = 10,
  parameter int START_PC = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr_in,
  input  logic             branch,
  input  logic             taken,
  input  logic             halt,
  input  logic             lut_we,
  input  logic [4:0]       lut_addr,
  input  logic [PC_W-1:0]  lut_data,
  output logic [PC_W-1:0]  pc_addr,
  output logic [5:0]       opcode_out,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] lut [32];
  logic [CNT_W-1:0] cnt;
  assign pc_addr = pc;
  assign cycle_count = cnt;
  always_comb opcode_out = running ? instr_in[8:3] : 6'b110111;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      cnt <= '0;
      running <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < 32; i++) lut[i] <= '0;
    end else begin
      if (lut_we) lut[lut_addr] <= lut_data;
      case (state)
        RUN: begin
          cnt <= &cnt ? cnt : cnt + CNT_W'(1);
          if (halt) begin
            state <= DONE;
            running <= 1'b0;
            done <= 1'b1;
          end else begin
            pc <= (branch && taken) ? lut[instr_in[4:0]] : pc + PC_W'(1);
          end
        end
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            pc <= PC_W'(START_PC);
            cnt <= '0;
            running <= 1'b1;
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          running <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench driving directed and random programs against a reference model
module tb_fetch_sequencer;
  localparam int PW = 8;
  localparam int CW = 8;
  localparam int SPC = 0;
  localparam logic [8:0] ADD = 9'b000001_000;
  localparam logic [8:0] HLT = 9'b110111_000;
  logic clk = 1'b0;
  logic reset, start, branch, taken, halt, lut_we;
  logic [8:0] instr_in;
  logic [4:0] lut_addr;
  logic [PW-1:0] lut_data, pc_addr;
  logic [5:0] opcode_out;
  logic running, done;
  logic [CW-1:0] cycle_count;
  fetch_sequencer #(.PC_W(PW), .START_PC(SPC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .branch(branch), .taken(taken), .halt(halt), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_data(lut_data), .pc_addr(pc_addr),
    .opcode_out(opcode_out), .running(running), .done(done),
    .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    int pc;
    int run;
    int dn;
    int cnt;
    int op;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int m_pc, m_cnt, m_run, m_done;
  int m_lut [32];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_addr", int'(pc_addr), e.pc);
      chk("running", int'(running), e.run);
      chk("done", int'(done), e.dn);
      chk("cycle_count", int'(cycle_count), e.cnt);
      chk("opcode_out", int'(opcode_out), e.op);
    end
  end
  task automatic model_reset();
    m_pc = 0;
    m_cnt = 0;
    m_run = 0;
    m_done = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = 0;
  endtask
  task automatic cyc(input bit r, input bit s, input logic [8:0] ins, input bit b = 0,
                     input bit t = 0, input bit h = 0, input bit w = 0, input int a = 0,
                     input int d = 0);
    exp_t e;
    int tgt;
    reset = r;
    start = s;
    instr_in = ins;
    branch = b;
    taken = t;
    halt = h;
    lut_we = w;
    lut_addr = 5'(a);
    lut_data = PW'(d);
    e.pc = m_pc;
    e.run = m_run;
    e.dn = m_done;
    e.cnt = m_cnt;
    e.op = m_run ? int'(ins[8:3]) : 55;
    q.push_back(e);
    tgt = m_lut[ins[4:0]];
    if (r) model_reset();
    else begin
      if (m_run == 1) begin
        m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
        if (h) begin
          m_run = 0;
          m_done = 1;
        end else m_pc = (b && t) ? tgt : (m_pc + 1) % (1 << PW);
      end else if (s) begin
        m_pc = SPC;
        m_cnt = 0;
        m_run = 1;
        m_done = 0;
      end
      if (w) m_lut[a % 32] = d % (1 << PW);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr_in = '0;
    branch = 1'b0;
    taken = 1'b0;
    halt = 1'b0;
    lut_we = 1'b0;
    lut_addr = '0;
    lut_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    cyc(0, 0, ADD, 0, 0, 0, 1, 3, 40);
    cyc(0, 1, ADD);
    cyc(0, 0, ADD);
    cyc(0, 0, ADD);
    cyc(0, 0, ADD);
    cyc(0, 0, HLT, 0, 0, 1);
    cyc(0, 0, ADD);
    cyc(0, 1, ADD);
    cyc(0, 0, ADD, 0, 0, 0, 1, 5, 100);
    cyc(0, 1, ADD);
    cyc(0, 0, ADD);
    cyc(0, 0, 9'b100000_101, 1, 1);
    cyc(0, 0, ADD);
    cyc(0, 0, ADD);
    cyc(0, 0, HLT, 0, 0, 1);
    cyc(0, 1, ADD);
    cyc(0, 0, ADD);
    cyc(0, 0, 9'b100000_101, 1, 0);
    cyc(0, 0, 9'b100000_101, 1, 1, 1);
    cyc(0, 0, ADD);
    cyc(0, 1, ADD);
    cyc(0, 0, 9'b100000_101, 1, 1, 0, 1, 5, 200);
    cyc(0, 0, ADD);
    cyc(0, 1, ADD);
    cyc(0, 0, 9'b100000_101, 1, 1);
    cyc(0, 0, ADD);
    for (int i = 0; i < 262; i++) cyc(0, 0, ADD);
    cyc(1, 1, ADD);
    cyc(0, 0, ADD);
    cyc(0, 1, ADD);
    cyc(0, 0, 9'b100000_101, 1, 1);
    cyc(0, 0, HLT, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, 9'($urandom_range(0, 511)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
          $urandom_range(0, 4) == 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and program-counter sequencer. It drives the opcode stream into the control decoder and acts on that decoder's branch/taken/halt outputs.
- Holds the PC and a 32-entry branch-target lookup table (LUT). It also provides the start/done program handshake and a run-cycle counter.
- Sits between the instruction ROM (combinational read, addressed by pc_addr) and the control decoder.

Parameters:
- PC_W, 10, PC and ROM address width.
- START_PC, 0, PC loaded on each accepted start.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins program execution.
- instr_in  in  9  ROM word at pc_addr, same cycle; [8:3] opcode, [4:0] LUT index.
- branch  in  1  from control decoder.
- taken  in  1  from control decoder.
- halt  in  1  from control decoder.
- lut_we  in  1  branch-target LUT write enable.
- lut_addr  in  5  LUT write index.
- lut_data  in  PC_W  LUT write data (absolute target PC).
- pc_addr  out  PC_W  current PC to instruction ROM.
- opcode_out  out  6  opcode to control decoder.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- cycle_count  out  CNT_W  RUN cycles since the last accepted start.

Behaviour:
- Reset (synchronous, highest priority, valid in any state including mid-RUN):
  - state=IDLE, pc=0, cycle_count=0.
  - All 32 LUT entries cleared to 0.
  - running=0, done=0.
- opcode_out = instr_in[8:3] when running=1, else 6'b110111 (HALT encoding).
  - The decoder therefore never sees a LOAD/STORE while idle.
- pc_addr = pc, registered output, all states.
- State IDLE:
  - start=1 -> pc<=START_PC, cycle_count<=0, next state RUN.
  - Otherwise everything holds.
- State RUN, evaluated each cycle on the current instr_in and decoder outputs (priority order):
  - halt=1 -> next state DONE, pc holds. Halt wins over a simultaneous branch.
  - branch=1 and taken=1 -> pc<=LUT[instr_in[4:0]].
  - Otherwise pc<=pc+1, modulo 2^PC_W: pc at all-ones wraps to 0 with no flag.
  - branch=1 with taken=0 -> treated as fall-through (pc+1).
  - cycle_count increments each RUN cycle, including the halt cycle; it saturates at all-ones.
  - start during RUN is ignored.
- State DONE:
  - done=1; pc and cycle_count hold.
  - start=1 -> pc<=START_PC, cycle_count<=0, next state RUN; done drops the next cycle.
- Latency:
  - One instruction per cycle, no stalls.
  - A branch target appears on pc_addr the cycle after the branch instruction.
  - done rises the cycle after the halt instruction is presented.
- LUT:
  - Written synchronously whenever lut_we=1, in any state.
  - Read is combinational.
  - Same-cycle write and branch to the same index -> the branch uses the old entry; the new value is visible the next cycle.
- reset and start asserted together -> reset wins, state=IDLE.

Test Plan:
- Reset, write LUT[3]=10'd40, start; ROM: addr0..2 ADD-type, addr3 HALT (opcode 110111) -> pc_addr sequence 0,1,2,3; done=1 at cycle 5 after start; cycle_count=4; pc_addr holds 3.
- LUT[5]=10'd100; ROM addr1 = B-type with branch=1, taken=1, instr_in[4:0]=5 -> pc_addr 0,1,100,101.
- Same program with taken=0 -> pc_addr 0,1,2; branch and halt both high at addr2 -> DONE, pc_addr stays 2.
- lut_we with lut_addr=5, lut_data=200 in the same cycle as a taken branch via index 5 (old value 100) -> next pc_addr=100; a repeat branch via index 5 afterward -> 200.
- PC_W=4, ROM all ADD, run from 0 -> pc_addr 14,15,0,1 with no halt; reset asserted at pc=1 -> next cycle pc_addr=0, running=0, cycle_count=0, LUT[5] reads 0.
- In DONE with cycle_count=4, pulse start -> running=1 next cycle, pc_addr=START_PC, cycle_count restarts from 0. start pulsed during RUN -> no effect on pc_addr or count. In IDLE, opcode_out=6'b110111.
